mem_access_unit: RTL and testbench

//  MEM-stage load/store engine between the pipeline and a variable-latency data memory.

---
 rtl/mem_access_unit_if.sv | 32 +++
 rtl/mem_access_unit.sv | 196 +++++++++++++++++++
 tb/tb_mem_access_unit.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// Memory-side bus of the MEM-stage load/store engine.
//   master : the access unit (drives request, address, byte enables, store data)
//   slave  : the data memory (answers with ack and the aligned read word)
// Signals:
//   mem_req   request, held for the whole access
//   mem_we    write strobe, meaningful only while mem_req=1
//   mem_addr  word-aligned byte address
//   mem_be    byte enables (all ones on loads)
//   mem_wdata lane-replicated store data
//   mem_ack   memory accepted the write / returned mem_rdata
//   mem_rdata aligned 32-bit read word
interface mem_access_unit_if #(
  parameter int ADDR_W = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata;
  logic              mem_ack;
  logic [31:0]       mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine between the pipeline and a variable-latency
// data memory. Checks alignment/legality, issues one req/ack transaction with
// a timeout, extends load data and reports a one-cycle completion pulse.
// Ports:
//   clk, reset            clock (rising edge), asynchronous active-high reset
//   req_valid/we/type/addr/wdata   access presented by the pipeline
//   stall                 freezes the pipeline until the access resolves
//   done                  one-cycle completion pulse
//   rdata, exc, exc_code  result, valid while done=1, held until next done
//   mem                   memory bus (master side)
module mem_access_unit #(
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT     = 16,
  parameter bit EN_UNSIGNED = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [2:0]        req_type,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              stall,
  output logic              done,
  output logic [31:0]       rdata,
  output logic              exc,
  output logic [1:0]        exc_code,
  mem_access_unit_if.master mem
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg;
  logic [2:0]        type_reg;
  logic [1:0]        lane_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic              we_reg;
  logic [3:0]        be_reg;
  logic [31:0]       wdata_reg;
  logic [31:0]       rdata_reg;
  logic              exc_reg;
  logic [1:0]        code_reg;

  logic              type_ok, aligned, legal, timeout;
  logic [3:0]        be_calc;
  logic [31:0]       wdata_calc;
  logic [15:0]       half_sel;
  logic [7:0]        byte_sel;
  logic [31:0]       load_ext;

  // Legality of the presented access. Unsigned types are loads only, and
  // only when enabled; encodings above 100 are never legal.
  always_comb begin
    type_ok = 1'b0;
    aligned = 1'b1;
    case (req_type)
      3'b000: begin
        type_ok = 1'b1;
        aligned = (req_addr[1:0] == 2'b00);
      end
      3'b001: begin
        type_ok = 1'b1;
        aligned = ~req_addr[0];
      end
      3'b010: type_ok = 1'b1;
      3'b011: begin
        type_ok = ~req_we & EN_UNSIGNED;
        aligned = ~req_addr[0];
      end
      3'b100: type_ok = ~req_we & EN_UNSIGNED;
      default: type_ok = 1'b0;
    endcase
    legal = type_ok & aligned;
  end

  // Byte enables and lane-replicated store data; loads read the whole word.
  always_comb begin
    be_calc    = 4'b1111;
    wdata_calc = req_wdata;
    case (req_type)
      3'b001, 3'b011: begin
        be_calc    = req_addr[1] ? 4'b1100 : 4'b0011;
        wdata_calc = {2{req_wdata[15:0]}};
      end
      3'b010, 3'b100: begin
        be_calc    = 4'b0001 << req_addr[1:0];
        wdata_calc = {4{req_wdata[7:0]}};
      end
      default: ;
    endcase
    if (!req_we) be_calc = 4'b1111;
  end

  // Lane extraction and extension of the returned word.
  always_comb begin
    half_sel = lane_reg[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];
    case (lane_reg)
      2'd0:    byte_sel = mem.mem_rdata[7:0];
      2'd1:    byte_sel = mem.mem_rdata[15:8];
      2'd2:    byte_sel = mem.mem_rdata[23:16];
      default: byte_sel = mem.mem_rdata[31:24];
    endcase
    case (type_reg)
      3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
      3'b010:  load_ext = {{24{byte_sel[7]}}, byte_sel};
      3'b011:  load_ext = {16'h0000, half_sel};
      3'b100:  load_ext = {24'h000000, byte_sel};
      default: load_ext = mem.mem_rdata;
    endcase
  end

  assign timeout = (cnt_reg == CNT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (req_valid) state_next = legal ? BUSY : DONE;
      BUSY:    if (mem.mem_ack || timeout) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_reg   <= '0;
      type_reg  <= 3'b000;
      lane_reg  <= 2'b00;
      addr_reg  <= '0;
      we_reg    <= 1'b0;
      be_reg    <= 4'b0000;
      wdata_reg <= 32'h0;
      rdata_reg <= 32'h0;
      exc_reg   <= 1'b0;
      code_reg  <= 2'b00;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            if (legal) begin
              addr_reg  <= {req_addr[ADDR_W-1:2], 2'b00};
              we_reg    <= req_we;
              be_reg    <= be_calc;
              wdata_reg <= wdata_calc;
              type_reg  <= req_type;
              lane_reg  <= req_addr[1:0];
              cnt_reg   <= '0;
            end else begin
              rdata_reg <= 32'h0;
              exc_reg   <= 1'b1;
              code_reg  <= req_we ? 2'b10 : 2'b01;
            end
          end
        end
        BUSY: begin
          cnt_reg <= cnt_reg + 1'b1;
          // An ack arriving on the final wait cycle still completes normally.
          if (mem.mem_ack) begin
            rdata_reg <= load_ext;
            exc_reg   <= 1'b0;
            code_reg  <= 2'b00;
          end else if (timeout) begin
            rdata_reg <= 32'h0;
            exc_reg   <= 1'b1;
            code_reg  <= 2'b11;
          end
        end
        default: ;
      endcase
    end
  end

  // Reset gates stall so the pipeline is released as soon as reset rises,
  // even if the stage still presents an access.
  assign stall = ~reset & (((state_reg == IDLE) & req_valid) | (state_reg == BUSY));
  assign done  = (state_reg == DONE);
  assign rdata    = rdata_reg;
  assign exc      = exc_reg;
  assign exc_code = code_reg;

  assign mem.mem_req   = (state_reg == BUSY);
  assign mem.mem_we    = we_reg;
  assign mem.mem_addr  = addr_reg;
  assign mem.mem_be    = be_reg;
  assign mem.mem_wdata = wdata_reg;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed cases followed by random
// accesses, each compared against a byte-arithmetic reference model.
module tb_mem_access_unit;

  localparam int ADDR_W      = 32;
  localparam int TIMEOUT     = 16;
  localparam bit EN_UNSIGNED = 1'b1;
  localparam int NEVER       = 1000;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_we;
  logic [2:0]  req_type;
  logic [31:0] req_addr, req_wdata;
  logic        stall, done, exc;
  logic [31:0] rdata;
  logic [1:0]  exc_code;

  int n_checks = 0;
  int n_fail   = 0;

  mem_access_unit_if #(.ADDR_W(ADDR_W)) bus ();

  mem_access_unit #(
    .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT), .EN_UNSIGNED(EN_UNSIGNED)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_we(req_we), .req_type(req_type),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall), .done(done), .rdata(rdata), .exc(exc), .exc_code(exc_code),
    .mem(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: access size in bytes, offset within the word, and
  // shift/mask arithmetic over the memory word.
  task automatic model(input logic we, input logic [2:0] ty, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] mrd,
                       output bit illegal, output logic [1:0] code, output logic [3:0] be,
                       output logic [31:0] mwd, output logic [31:0] rd);
    int size;
    bit sgn;
    int off;
    logic [31:0] mask, v;
    off  = int'(addr % 4);
    sgn  = 1'b0;
    size = 0;
    case (ty)
      3'd0: size = 4;
      3'd1: begin size = 2; sgn = 1'b1; end
      3'd2: begin size = 1; sgn = 1'b1; end
      3'd3: size = 2;
      3'd4: size = 1;
      default: size = 0;
    endcase
    illegal = (size == 0) || (we && ty > 3'd2) || (!we && ty > 3'd2 && !EN_UNSIGNED);
    if (size != 0 && (off % size) != 0) illegal = 1'b1;
    code = we ? 2'b10 : 2'b01;
    if (size == 0) size = 4;
    be = we ? 4'(((1 << size) - 1) << off) : 4'hF;
    for (int i = 0; i < 4; i++) mwd[8*i +: 8] = wdata[8*(i % size) +: 8];
    mask = (size == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8*size)) - 32'h1);
    v = (mrd >> (8*off)) & mask;
    if (sgn && size < 4 && v[8*size-1]) v = v | ~mask;
    rd = v;
  endtask

  // One access: present it, play the memory with an ack after `delay`
  // wait cycles (NEVER = no ack), then check the completion.
  task automatic access(input string tag, input logic we, input logic [2:0] ty,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] mrd, input int delay);
    bit illegal;
    logic [1:0] code;
    logic [3:0] be;
    logic [31:0] mwd, rd;
    int busy;
    bit finished;
    int exp_busy;
    model(we, ty, addr, wdata, mrd, illegal, code, be, mwd, rd);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_type = ty; req_addr = addr; req_wdata = wdata;
    bus.mem_ack = 1'b0;
    #1;
    check({tag, ".stall_idle"}, 32'(stall), 32'd1);
    check({tag, ".req_idle"}, 32'(bus.mem_req), 32'd0);
    busy = 0;
    if (illegal) begin
      @(negedge clk); #1;
      check({tag, ".done"}, 32'(done), 32'd1);
      check({tag, ".exc"}, 32'(exc), 32'd1);
      check({tag, ".code"}, 32'(exc_code), 32'(code));
      check({tag, ".no_req"}, 32'(bus.mem_req), 32'd0);
      check({tag, ".stall_done"}, 32'(stall), 32'd0);
    end else begin
      finished = 1'b0;
      while (!finished && busy <= TIMEOUT + 1) begin
        @(negedge clk); #1;
        if (done) finished = 1'b1;
        else begin
          check({tag, ".mem_req"}, 32'(bus.mem_req), 32'd1);
          check({tag, ".stall_busy"}, 32'(stall), 32'd1);
          check({tag, ".mem_addr"}, bus.mem_addr, addr & 32'hFFFF_FFFC);
          check({tag, ".mem_be"}, 32'(bus.mem_be), 32'(be));
          check({tag, ".mem_we"}, 32'(bus.mem_we), 32'(we));
          if (we) check({tag, ".mem_wdata"}, bus.mem_wdata, mwd);
          bus.mem_ack   = (busy == delay);
          bus.mem_rdata = (busy == delay) ? mrd : $urandom;
          // The pipeline side may change; the bus must not follow it.
          req_addr  = $urandom;
          req_wdata = $urandom;
          busy++;
        end
      end
      bus.mem_ack = 1'b0;
      exp_busy = (delay < TIMEOUT) ? delay + 1 : TIMEOUT;
      check({tag, ".done_seen"}, 32'(finished), 32'd1);
      check({tag, ".busy_cycles"}, 32'(busy), 32'(exp_busy));
      check({tag, ".req_in_done"}, 32'(bus.mem_req), 32'd0);
      check({tag, ".stall_done"}, 32'(stall), 32'd0);
      if (delay < TIMEOUT) begin
        check({tag, ".exc"}, 32'(exc), 32'd0);
        check({tag, ".rdata"}, rdata, we ? rdata : rd);
        if (!we) check({tag, ".rdata"}, rdata, rd);
      end else begin
        check({tag, ".exc"}, 32'(exc), 32'd1);
        check({tag, ".code"}, 32'(exc_code), 32'd3);
        check({tag, ".rdata"}, rdata, 32'd0);
      end
    end
    // req_valid stayed high through DONE; the unit must now be idle.
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    check({tag, ".done_pulse"}, 32'(done), 32'd0);
    check({tag, ".idle_req"}, 32'(bus.mem_req), 32'd0);
    check({tag, ".idle_stall"}, 32'(stall), 32'd0);
    $display("txn %s we=%0d type=%0d addr=%h wdata=%h mrdata=%h delay=%0d busy=%0d rdata=%h exc=%0d code=%0d",
             tag, we, ty, addr, wdata, mrd, delay, busy, rdata, exc, exc_code);
  endtask

  initial begin
    logic [31:0] hi;
    reset = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_type = 3'd0; req_addr = 32'h0; req_wdata = 32'h0;
    bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0;
    repeat (2) @(negedge clk);
    #1;
    check("rst.stall", 32'(stall), 32'd0);
    check("rst.done", 32'(done), 32'd0);
    check("rst.rdata", rdata, 32'd0);
    check("rst.exc", 32'(exc), 32'd0);
    check("rst.code", 32'(exc_code), 32'd0);
    check("rst.mem_req", 32'(bus.mem_req), 32'd0);
    check("rst.mem_we", 32'(bus.mem_we), 32'd0);
    check("rst.mem_be", 32'(bus.mem_be), 32'd0);
    check("rst.mem_addr", bus.mem_addr, 32'd0);
    check("rst.mem_wdata", bus.mem_wdata, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    hi = $urandom & 32'hFFFF_FFFC;
    access("lb_delay2",  1'b0, 3'd2, hi | 32'd3, 32'h0, 32'h80FF_1234, 2);
    access("lhu_imm",    1'b0, 3'd3, hi | 32'd2, 32'h0, 32'h8001_0000, 0);
    access("lh_imm",     1'b0, 3'd1, hi | 32'd2, 32'h0, 32'h8001_0000, 0);
    access("sb_lane1",   1'b1, 3'd2, hi | 32'd1, 32'h0000_00A5, 32'h0, 3);
    access("lw_misal",   1'b0, 3'd0, hi | 32'd2, 32'h0, 32'h0, 0);
    access("sh_misal",   1'b1, 3'd1, hi | 32'd1, 32'h1234, 32'h0, 0);
    access("st_type011", 1'b1, 3'd3, hi, 32'h1234, 32'h0, 0);
    access("lw_timeout", 1'b0, 3'd0, hi, 32'h0, 32'hDEAD_BEEF, NEVER);
    access("lw_lastack", 1'b0, 3'd0, hi, 32'h0, 32'hCAFE_F00D, TIMEOUT - 1);
    access("sw_word",    1'b1, 3'd0, hi | 32'd4, 32'h1357_9BDF, 32'h0, 1);
    access("sh_upper",   1'b1, 3'd1, hi | 32'd2, 32'hFFFF_BEEF, 32'h0, 0);

    for (int i = 0; i < 40; i++) begin
      access("rand", 1'($urandom_range(0, 1)), 3'($urandom_range(0, 4)), $urandom,
             $urandom, $urandom,
             ($urandom_range(0, 9) == 0) ? NEVER : int'($urandom_range(0, 4)));
    end

    // Reset in the middle of a wait.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_type = 3'd0; req_addr = 32'h0000_0100;
    bus.mem_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rstbusy.req_before", 32'(bus.mem_req), 32'd1);
    reset = 1'b1;
    #1;
    check("rstbusy.req_drop", 32'(bus.mem_req), 32'd0);
    check("rstbusy.stall_drop", 32'(stall), 32'd0);
    check("rstbusy.done", 32'(done), 32'd0);
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    bus.mem_ack = 1'b1;
    bus.mem_rdata = 32'h1111_2222;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      check("late_ack.done", 32'(done), 32'd0);
      check("late_ack.mem_req", 32'(bus.mem_req), 32'd0);
      check("late_ack.rdata", rdata, 32'd0);
    end
    bus.mem_ack = 1'b0;
    access("after_rst", 1'b0, 3'd4, 32'h0000_0201, 32'h0, 32'h0000_F700, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
